// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_W payload bits LSB first, then one parity bit.
// Optional saturating parity-error counter on err_cnt when ERR_CNT_EN is defined.
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              par_err,
    output logic              busy
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   shreg;
    logic                par;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            par_err  <= 1'b0;
            busy     <= 1'b0;
`ifdef ERR_CNT_EN
            err_cnt  <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DATA;
                        count <= '0;
                        par   <= ODD;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        shreg[count] <= bit_in;
                        par          <= par ^ bit_in;
                        count        <= count + 1'b1;
                        if (count == CW'(DATA_W - 1))
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    // data_out only moves here, so partial frames never leak out
                    if (bit_valid) begin
                        data_out <= shreg;
                        par_err  <= (bit_in != par);
                        done     <= 1'b1;
                        state    <= DONE;
`ifdef ERR_CNT_EN
                        if ((bit_in != par) && (err_cnt != 8'hFF))
                            err_cnt <= err_cnt + 8'd1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed and randomized frames into an even-sense and an odd-sense checker,
// compared against a payload-level parity model.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    logic rst, start, bit_in, bit_valid;
    logic [7:0] d0_data, d1_data;
    logic d0_done, d1_done, d0_err, d1_err, d0_busy, d1_busy;
`ifdef ERR_CNT_EN
    logic [7:0] d0_cnt, d1_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_data [2];
    logic       exp_err  [2];
    int         exp_cnt  [2];

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(d0_data), .done(d0_done), .par_err(d0_err), .busy(d0_busy)
`ifdef ERR_CNT_EN
        , .err_cnt(d0_cnt)
`endif
    );

    parity_frame_checker #(.DATA_W(8), .ODD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(d1_data), .done(d1_done), .par_err(d1_err), .busy(d1_busy)
`ifdef ERR_CNT_EN
        , .err_cnt(d1_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle on which no frame may complete.
    task automatic tick_q(input string tag);
        tick();
        chk({tag, "_done0"}, {31'd0, d0_done}, 32'd0);
        chk({tag, "_done1"}, {31'd0, d1_done}, 32'd0);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_data0"}, {24'd0, d0_data}, {24'd0, exp_data[0]});
        chk({tag, "_data1"}, {24'd0, d1_data}, {24'd0, exp_data[1]});
        chk({tag, "_err0"},  {31'd0, d0_err},  {31'd0, exp_err[0]});
        chk({tag, "_err1"},  {31'd0, d1_err},  {31'd0, exp_err[1]});
`ifdef ERR_CNT_EN
        chk({tag, "_cnt0"},  {24'd0, d0_cnt},  exp_cnt[0]);
        chk({tag, "_cnt1"},  {24'd0, d1_cnt},  exp_cnt[1]);
`endif
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            exp_data[k] = 8'd0;
            exp_err[k]  = 1'b0;
            exp_cnt[k]  = 0;
        end
    endtask

    // gap < 0 selects a random 0..3 idle-cycle gap before every bit.
    task automatic send_frame(input string tag, input logic [7:0] pay, input logic pb, input int gap);
        int g;
        start = 1'b1; bit_valid = 1'b0;
        tick_q({tag, "_start"});
        start = 1'b0;
        chk({tag, "_busy0"}, {31'd0, d0_busy}, 32'd1);
        chk({tag, "_busy1"}, {31'd0, d1_busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                start     = 1'($urandom);
                tick_q({tag, "_gap"});
                start = 1'b0;
            end
            bit_valid = 1'b1;
            bit_in    = (i < 8) ? pay[i] : pb;
            if (i < 8) tick_q({tag, "_bit"});
            else       tick();
        end
        bit_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_data[k] = pay;
            exp_err[k]  = ((^pay) ^ k[0]) != pb;
            if (exp_err[k] && exp_cnt[k] < 255) exp_cnt[k]++;
        end
        chk({tag, "_pulse0"}, {31'd0, d0_done}, 32'd1);
        chk({tag, "_pulse1"}, {31'd0, d1_done}, 32'd1);
        chk_held({tag, "_res"});
        tick_q({tag, "_after"});
        chk({tag, "_idle0"}, {31'd0, d0_busy}, 32'd0);
        chk({tag, "_idle1"}, {31'd0, d1_busy}, 32'd0);
        chk_held({tag, "_hold"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        reset_model();
        tick();
        tick();
        chk("rst_done0", {31'd0, d0_done}, 32'd0);
        chk("rst_busy0", {31'd0, d0_busy}, 32'd0);
        chk("rst_busy1", {31'd0, d1_busy}, 32'd0);
        chk_held("rst");
        rst = 1'b0; start = 1'b0;

        // bit_valid in IDLE must not start or advance anything
        repeat (3) begin
            bit_valid = 1'b1; bit_in = 1'($urandom);
            tick_q("idle_bits");
            chk("idle_busy", {31'd0, d0_busy}, 32'd0);
        end
        bit_valid = 1'b0;

        send_frame("even_a5", 8'hA5, 1'b0, 0);
        send_frame("err_a5",  8'hA5, 1'b1, 0);
        send_frame("gap_3c",  8'h3C, 1'b0, 2);

        // reset after four bits discards the frame
        start = 1'b1; tick_q("mid_start"); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick_q("mid_bit");
        end
        rst = 1'b1; start = 1'b1;
        tick_q("mid_rst");
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        reset_model();
        chk("mid_busy0", {31'd0, d0_busy}, 32'd0);
        chk("mid_busy1", {31'd0, d1_busy}, 32'd0);
        chk_held("mid");
        repeat (3) tick_q("mid_quiet");
        send_frame("full_ff", 8'hFF, 1'b0, 0);

        send_frame("odd_00_p1", 8'h00, 1'b1, 0);
        send_frame("odd_00_p0", 8'h00, 1'b0, 0);

        repeat (40) send_frame("rand", 8'($urandom), 1'($urandom), -1);

`ifdef ERR_CNT_EN
        repeat (260) send_frame("sat", 8'h00, 1'b1, 0);
        chk("sat_cnt0", {24'd0, d0_cnt}, 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
